// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// stopwatch_ctrl
//   Stopwatch sequencer in front of the contadorN millisecond counter.
//   Converts one-cycle StartStop / Lap / Clear pulses into the counter's
//   Enable and Nreset, freezes a lap value on Display and stops the count
//   at MAX_COUNT. All state updates happen on the falling edge of NEclk.
//
// Ports
//   NEclk      in   clock (falling-edge active), 1 ms period
//   Reset      in   asynchronous, active-high; forces IDLE
//   StartStop  in   pulse: start/resume or pause
//   Lap        in   pulse: freeze / unfreeze Display
//   Clear      in   pulse: back to zero (paused or DONE only)
//   count      in   contadorN count value
//   CntEnable  out  contadorN Enable
//   CntNreset  out  contadorN Nreset (0 holds the counter at 0)
//   Display    out  value shown by count2watch
//   Running    out  counting (RUN, LAP_RUN)
//   LapActive  out  lap value frozen on Display (LAP_RUN, LAP_PAUSE)
//   Overflow   out  terminal count reached (DONE)
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | counter held at zero, waiting for StartStop
// RUN       | counting, Display follows count
// PAUSE     | count frozen, Display follows count
// LAP_RUN   | counting, Display shows lap_reg
// LAP_PAUSE | count frozen, Display shows lap_reg
// DONE      | MAX_COUNT reached, counter stopped until Clear
module stopwatch_ctrl #(
    parameter int BITS      = 26,
    parameter int MAX_COUNT = 35999999
) (
    input  logic            NEclk,
    input  logic            Reset,
    input  logic            StartStop,
    input  logic            Lap,
    input  logic            Clear,
    input  logic [BITS-1:0] count,
    output logic            CntEnable,
    output logic            CntNreset,
    output logic [BITS-1:0] Display,
    output logic            Running,
    output logic            LapActive,
    output logic            Overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_LAP_RUN,
        S_LAP_PAUSE,
        S_DONE
    } state_t;

    // The counter is still enabled on the edge where it sits at MAX_COUNT-1,
    // so it lands exactly on MAX_COUNT as the controller enters DONE.
    localparam logic [BITS-1:0] TERM = BITS'(MAX_COUNT - 1);

    state_t          state, state_nx;
    logic [BITS-1:0] lap_reg, lap_nx;
    logic            at_term;

    assign at_term = (count == TERM);

    always_ff @(negedge NEclk or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            lap_reg <= '0;
        end else begin
            state   <= state_nx;
            lap_reg <= lap_nx;
        end
    end

    // Clear outranks StartStop, which outranks Lap. A Clear that the current
    // state ignores simply falls through to the lower-priority checks.
    always_comb begin
        state_nx = state;
        lap_nx   = lap_reg;
        case (state)
            S_IDLE: begin
                if (StartStop) state_nx = S_RUN;
            end
            S_RUN: begin
                if (at_term) begin
                    state_nx = S_DONE;
                end else if (StartStop) begin
                    state_nx = S_PAUSE;
                end else if (Lap) begin
                    state_nx = S_LAP_RUN;
                    lap_nx   = count;
                end
            end
            S_LAP_RUN: begin
                if (at_term)        state_nx = S_DONE;
                else if (StartStop) state_nx = S_LAP_PAUSE;
                else if (Lap)       state_nx = S_RUN;
            end
            S_PAUSE: begin
                if (Clear)          state_nx = S_IDLE;
                else if (StartStop) state_nx = S_RUN;
            end
            S_LAP_PAUSE: begin
                if (Clear)          state_nx = S_IDLE;
                else if (StartStop) state_nx = S_LAP_RUN;
                else if (Lap)       state_nx = S_PAUSE;
            end
            S_DONE: begin
                if (Clear) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (state_nx == S_IDLE) lap_nx = '0;
    end

    // Outputs decode the registered state only, so they move one edge after
    // the pulse that caused the transition.
    assign Running   = (state == S_RUN) || (state == S_LAP_RUN);
    assign LapActive = (state == S_LAP_RUN) || (state == S_LAP_PAUSE);
    assign Overflow  = (state == S_DONE);
    assign CntEnable = Running;
    // Nreset rises together with Enable when leaving IDLE, so the first
    // enabled edge counts from zero; it falls as soon as IDLE is entered.
    assign CntNreset = (state != S_IDLE);
    assign Display   = LapActive ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    localparam int BITS = 26;
    localparam int MAXC = 200;

    logic            NEclk = 1'b1;
    logic            Reset = 1'b0;
    logic            StartStop = 1'b0;
    logic            Lap = 1'b0;
    logic            Clear = 1'b0;
    logic [BITS-1:0] count = '0;
    logic            CntEnable, CntNreset, Running, LapActive, Overflow;
    logic [BITS-1:0] Display;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    bit m_on, m_run, m_lap, m_done;
    int m_cnt, m_lapv;

    stopwatch_ctrl #(.BITS(BITS), .MAX_COUNT(MAXC)) dut (
        .NEclk(NEclk), .Reset(Reset), .StartStop(StartStop), .Lap(Lap),
        .Clear(Clear), .count(count), .CntEnable(CntEnable),
        .CntNreset(CntNreset), .Display(Display), .Running(Running),
        .LapActive(LapActive), .Overflow(Overflow)
    );

    always #5 NEclk = ~NEclk;

    // contadorN stand-in: async active-low clear, counts on falling edge
    always @(negedge NEclk or negedge CntNreset) begin
        if (!CntNreset)     count <= '0;
        else if (CntEnable) count <= count + 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic model_idle();
        m_on = 0; m_run = 0; m_lap = 0; m_done = 0; m_lapv = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic ss, input logic lp, input logic cl);
        int cnt_nx;
        cnt_nx = !m_on ? 0 : (m_run ? m_cnt + 1 : m_cnt);
        if (m_run && m_cnt == MAXC - 1) begin
            m_done = 1; m_run = 0; m_lap = 0;
        end else if (m_done) begin
            if (cl) model_idle();
        end else if (!m_on) begin
            if (ss) begin m_on = 1; m_run = 1; end
        end else if (cl && !m_run) begin
            model_idle();
        end else if (ss) begin
            m_run = !m_run;
        end else if (lp) begin
            if (m_run && !m_lap) begin m_lap = 1; m_lapv = m_cnt; end
            else m_lap = 0;
        end
        m_cnt = m_on ? cnt_nx : 0;
    endtask

    task automatic tick(input logic ss, input logic lp, input logic cl);
        StartStop = ss; Lap = lp; Clear = cl;
        @(negedge NEclk);
        model_step(ss, lp, cl);
        #1;
        StartStop = 0; Lap = 0; Clear = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge NEclk);
        #2 Reset = 1'b1;
        model_idle();
        #2 Reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge NEclk);
        #2 Reset = 1'b1;
        model_idle();
        #1;
        n_total++;
        if ({CntEnable, CntNreset, Running, LapActive, Overflow} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000",
                     {CntEnable, CntNreset, Running, LapActive, Overflow});
        else n_pass++;
        n_total++;
        if (Display !== '0 || count !== '0)
            $display("FAIL reset_display got %0d/%0d want 0/0", Display, count);
        else n_pass++;
        #1 Reset = 1'b0;
    endtask

    task automatic test_start();
        ticks(4);
        tick(1, 0, 0);
        n_total++;
        if (CntEnable !== 1'b1 || CntNreset !== 1'b1 || count !== 0)
            $display("FAIL start_enable got en=%b nrst=%b cnt=%0d want 1 1 0",
                     CntEnable, CntNreset, count);
        else n_pass++;
        ticks(100);
        n_total++;
        if (count !== 100 || Display !== 100 || Running !== 1'b1)
            $display("FAIL start_count got cnt=%0d disp=%0d run=%b want 100 100 1",
                     count, Display, Running);
        else n_pass++;
    endtask

    task automatic test_clear();
        tick(0, 0, 1);
        n_total++;
        if (Running !== 1'b1 || count !== 101)
            $display("FAIL clear_in_run got run=%b cnt=%0d want 1 101", Running, count);
        else n_pass++;
        tick(1, 0, 0);
        ticks(5);
        n_total++;
        if (Running !== 1'b0 || count !== 102 || Display !== 102 || CntNreset !== 1'b1)
            $display("FAIL pause_freeze got run=%b cnt=%0d disp=%0d nrst=%b want 0 102 102 1",
                     Running, count, Display, CntNreset);
        else n_pass++;
        tick(0, 0, 1);
        n_total++;
        if (CntNreset !== 1'b0 || count !== 0 || Display !== 0)
            $display("FAIL clear_idle got nrst=%b cnt=%0d disp=%0d want 0 0 0",
                     CntNreset, count, Display);
        else n_pass++;
    endtask

    task automatic test_lap();
        tick(1, 0, 0);
        ticks(50);
        tick(0, 1, 0);
        ticks(10);
        n_total++;
        if (LapActive !== 1'b1 || Display !== 50 || count !== 61)
            $display("FAIL lap_freeze got lap=%b disp=%0d cnt=%0d want 1 50 61",
                     LapActive, Display, count);
        else n_pass++;
        ticks(19);
        tick(0, 1, 0);
        n_total++;
        if (LapActive !== 1'b0 || Display !== 81 || count !== 81)
            $display("FAIL lap_release got lap=%b disp=%0d cnt=%0d want 0 81 81",
                     LapActive, Display, count);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        tick(1, 1, 0);
        n_total++;
        if (Running !== 1'b0 || LapActive !== 1'b0 || count !== 82)
            $display("FAIL ss_beats_lap got run=%b lap=%b cnt=%0d want 0 0 82",
                     Running, LapActive, count);
        else n_pass++;
        tick(1, 0, 1);
        n_total++;
        if (CntNreset !== 1'b0 || CntEnable !== 1'b0 || count !== 0)
            $display("FAIL clear_beats_ss got nrst=%b en=%b cnt=%0d want 0 0 0",
                     CntNreset, CntEnable, count);
        else n_pass++;
        tick(1, 0, 0);
        ticks(10);
        tick(0, 1, 0);
        ticks(5);
        tick(1, 0, 0);
        n_total++;
        if (Running !== 1'b0 || LapActive !== 1'b1 || Display !== 10 || count !== 17)
            $display("FAIL lap_pause got run=%b lap=%b disp=%0d cnt=%0d want 0 1 10 17",
                     Running, LapActive, Display, count);
        else n_pass++;
        tick(1, 0, 0);
        ticks(3);
        n_total++;
        if (Running !== 1'b1 || LapActive !== 1'b1 || Display !== 10 || count !== 20)
            $display("FAIL lap_resume got run=%b lap=%b disp=%0d cnt=%0d want 1 1 10 20",
                     Running, LapActive, Display, count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        @(posedge NEclk);
        #2 Reset = 1'b1;
        #1;
        n_total++;
        if (CntNreset !== 1'b0 || CntEnable !== 1'b0 || LapActive !== 1'b0 ||
            Display !== 0 || count !== 0)
            $display("FAIL async_reset got nrst=%b en=%b lap=%b disp=%0d cnt=%0d want 0 0 0 0 0",
                     CntNreset, CntEnable, LapActive, Display, count);
        else n_pass++;
        model_idle();
        #1 Reset = 1'b0;
    endtask

    task automatic test_terminal();
        tick(1, 0, 0);
        ticks(150);
        tick(0, 1, 0);
        ticks(48);
        n_total++;
        if (count !== MAXC - 1 || Overflow !== 1'b0 || Display !== 150)
            $display("FAIL term_before got cnt=%0d ovf=%b disp=%0d want %0d 0 150",
                     count, Overflow, Display, MAXC - 1);
        else n_pass++;
        tick(0, 0, 0);
        n_total++;
        if (count !== MAXC || Overflow !== 1'b1 || CntEnable !== 1'b0 ||
            LapActive !== 1'b0 || Display !== MAXC)
            $display("FAIL term_done got cnt=%0d ovf=%b en=%b lap=%b disp=%0d want %0d 1 0 0 %0d",
                     count, Overflow, CntEnable, LapActive, Display, MAXC, MAXC);
        else n_pass++;
        tick(1, 0, 0);
        tick(0, 1, 0);
        ticks(5);
        n_total++;
        if (count !== MAXC || Overflow !== 1'b1 || Running !== 1'b0 || Display !== MAXC)
            $display("FAIL done_ignores got cnt=%0d ovf=%b run=%b disp=%0d want %0d 1 0 %0d",
                     count, Overflow, Running, Display, MAXC, MAXC);
        else n_pass++;
        tick(0, 0, 1);
        n_total++;
        if (Overflow !== 1'b0 || count !== 0 || CntNreset !== 1'b0)
            $display("FAIL done_clear got ovf=%b cnt=%0d nrst=%b want 0 0 0",
                     Overflow, count, CntNreset);
        else n_pass++;
        tick(1, 0, 0);
        ticks(MAXC - 1);
        tick(1, 0, 0);
        n_total++;
        if (Overflow !== 1'b1 || count !== MAXC || Running !== 1'b0)
            $display("FAIL term_beats_button got ovf=%b cnt=%0d run=%b want 1 %0d 0",
                     Overflow, count, Running, MAXC);
        else n_pass++;
        tick(0, 0, 1);
    endtask

    task automatic test_random();
        logic [4:0] exp_ctrl;
        int         exp_disp;
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 24) == 0);
            exp_ctrl = {m_run, m_on, m_run, m_lap, m_done};
            exp_disp = m_lap ? m_lapv : m_cnt;
            n_total++;
            if ({CntEnable, CntNreset, Running, LapActive, Overflow} !== exp_ctrl)
                $display("FAIL rand_ctrl cycle %0d got %b want %b", i,
                         {CntEnable, CntNreset, Running, LapActive, Overflow}, exp_ctrl);
            else n_pass++;
            n_total++;
            if (count !== BITS'(m_cnt) || Display !== BITS'(exp_disp))
                $display("FAIL rand_value cycle %0d got cnt=%0d disp=%0d want %0d %0d",
                         i, count, Display, m_cnt, exp_disp);
            else n_pass++;
        end
    endtask

    initial begin
        model_idle();
        test_reset();
        test_start();
        test_clear();
        test_lap();
        test_simultaneous();
        test_async_reset();
        test_terminal();
        do_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
